sim_cfg_loader: RTL and testbench

Multi-word configuration loader for the calorimeter hit simulator. It continuously scans a window of on-chip HPS-shared RAM and collects N_WORDS configuration bytes into a shadow register. The full set is committed atomically to the simulator datapath only on a bunch-train orbit boundary. It replaces the single-address occupancy read in the simulator top. Occupancy, offset and mode therefore change coherently, never mid-orbit.

---
 rtl/sim_cfg_loader_pkg.sv | 9 +
 rtl/sim_cfg_rd_pipe.sv | 34 +++
 rtl/sim_cfg_loader.sv | 73 +++++++
 tb/tb_sim_cfg_loader.sv | 223 ++++++++++++++++++++++
 4 files changed

// File: rtl/sim_cfg_loader_pkg.sv
// sim_cfg_loader_pkg: shared config word map, loader FSM states and default reset config
package sim_cfg_loader_pkg;
  localparam int CFG_OCC    = 0;
  localparam int CFG_OFF_LO = 1;
  localparam int CFG_OFF_HI = 2;
  localparam int CFG_MODE   = 3;
  localparam logic [31:0] DEFAULT_RESET_CFG = 32'h0000_0000;
  typedef enum logic [1:0] {SCAN, DRAIN, READY} cfg_state_t;
endpackage

// File: rtl/sim_cfg_rd_pipe.sv
// sim_cfg_rd_pipe: RD_LATENCY-deep valid+index pipeline tracking outstanding RAM reads
// i_push/i_idx tag a read issued this cycle; o_vld/o_idx is the tag whose data is on the
// RAM bus now; o_empty means nothing is in flight behind the emerging tag.
module sim_cfg_rd_pipe #(
  parameter int RD_LATENCY = 1,
  parameter int IDX_W      = 2
)(
  input  logic             clk,
  input  logic             rst,
  input  logic             i_push,
  input  logic [IDX_W-1:0] i_idx,
  output logic             o_vld,
  output logic [IDX_W-1:0] o_idx,
  output logic             o_empty
);
  logic [RD_LATENCY-1:0] r_vld;
  logic [IDX_W-1:0]      r_idx [RD_LATENCY];
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      r_vld <= '0;
      for (int i = 0; i < RD_LATENCY; i++) r_idx[i] <= '0;
    end else begin
      r_vld[0] <= i_push;
      r_idx[0] <= i_idx;
      for (int i = 1; i < RD_LATENCY; i++) begin
        r_vld[i] <= r_vld[i-1];
        r_idx[i] <= r_idx[i-1];
      end
    end
  assign o_vld   = r_vld[RD_LATENCY-1];
  assign o_idx   = r_idx[RD_LATENCY-1];
  // The last stage is captured on the coming edge, so only earlier stages count as pending.
  assign o_empty = ~|(r_vld << 1);
endmodule

// File: rtl/sim_cfg_loader.sv
// sim_cfg_loader: scans N_WORDS RAM config bytes into a shadow and commits them on orbit_start
// clk/rst: clock and async active-high reset; ram_addr/ram_read: registered RAM read port;
// ram_rdata: RAM data; orbit_start: orbit boundary pulse; freeze: commit inhibit;
// cfg_active: committed config; cfg_update/cfg_changed: commit pulse and change flag;
// missed_commits: saturating count of orbits that found the scan unfinished.
module sim_cfg_loader import sim_cfg_loader_pkg::*; #(
  parameter int N_WORDS    = 4,
  parameter int ADDR_W     = 7,
  parameter int DATA_W     = 8,
  parameter int BASE_ADDR  = 0,
  parameter int RD_LATENCY = 1,
  parameter logic [N_WORDS*DATA_W-1:0] RESET_CFG = (N_WORDS*DATA_W)'(DEFAULT_RESET_CFG),
  parameter int MISS_W     = 8
)(
  input  logic                      clk,
  input  logic                      rst,
  output logic [ADDR_W-1:0]         ram_addr,
  output logic                      ram_read,
  input  logic [DATA_W-1:0]         ram_rdata,
  input  logic                      orbit_start,
  input  logic                      freeze,
  output logic [N_WORDS*DATA_W-1:0] cfg_active,
  output logic                      cfg_update,
  output logic                      cfg_changed,
  output logic [MISS_W-1:0]         missed_commits
);
  localparam int IDX_W = N_WORDS > 1 ? $clog2(N_WORDS) : 1;
  cfg_state_t                r_state, w_next;
  logic [IDX_W-1:0]          r_idx, w_tag_idx;
  logic [N_WORDS*DATA_W-1:0] r_shadow;
  logic w_push, w_last, w_commit, w_miss, w_tag_vld, w_empty;
  sim_cfg_rd_pipe #(.RD_LATENCY(RD_LATENCY), .IDX_W(IDX_W)) u_pipe (
    .clk(clk), .rst(rst), .i_push(w_push), .i_idx(r_idx),
    .o_vld(w_tag_vld), .o_idx(w_tag_idx), .o_empty(w_empty)
  );
  always_comb begin
    w_push   = r_state == SCAN;
    w_last   = w_push && r_idx == IDX_W'(N_WORDS-1);
    w_commit = r_state == READY && orbit_start && !freeze;
    w_miss   = r_state != READY && orbit_start;
    w_next   = r_state;
    case (r_state)
      SCAN:    w_next = w_last ? DRAIN : SCAN;
      DRAIN:   w_next = w_empty ? READY : DRAIN;
      READY:   w_next = w_commit ? SCAN : READY;
      default: w_next = SCAN;
    endcase
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      r_state        <= SCAN;
      r_idx          <= '0;
      r_shadow       <= RESET_CFG;
      ram_addr       <= ADDR_W'(BASE_ADDR);
      ram_read       <= 1'b0;
      cfg_active     <= RESET_CFG;
      cfg_update     <= 1'b0;
      cfg_changed    <= 1'b0;
      missed_commits <= '0;
    end else begin
      r_state  <= w_next;
      ram_read <= w_push;
      if (w_push) begin
        ram_addr <= ADDR_W'(BASE_ADDR) + ADDR_W'(r_idx);
        r_idx    <= w_last ? '0 : r_idx + IDX_W'(1);
      end
      if (w_tag_vld) r_shadow[int'(w_tag_idx)*DATA_W +: DATA_W] <= ram_rdata;
      if (w_commit) cfg_active <= r_shadow;
      cfg_update  <= w_commit;
      cfg_changed <= w_commit && r_shadow != cfg_active;
      if (w_miss && !(&missed_commits)) missed_commits <= missed_commits + MISS_W'(1);
    end
endmodule

// File: tb/tb_sim_cfg_loader.sv
// tb_sim_cfg_loader: randomized self-checking bench for two sim_cfg_loader configurations
module tb_sim_cfg_loader;
  localparam logic [47:0] RB = 48'h5A3C_0F00_81E7;
  logic clk = 0;
  always #5 clk = ~clk;
  logic rst [2];
  logic orb [2];
  logic frz [2];
  logic [6:0] addr [2];
  logic rd [2];
  logic [7:0] rdata [2];
  logic upd [2];
  logic chg [2];
  logic [7:0] miss [2];
  logic [31:0] act_a;
  logic [47:0] act_b;
  logic [47:0] act [2];
  logic [7:0] mem [2][128];
  logic [6:0] hb [2];
  assign act[0] = {16'h0, act_a};
  assign act[1] = act_b;
  // Device 0: asynchronous-read RAM (latency 1). Device 1: two extra address registers (latency 3).
  assign rdata[0] = mem[0][addr[0]];
  assign rdata[1] = mem[1][hb[1]];
  always @(posedge clk) begin
    hb[0] <= addr[1];
    hb[1] <= hb[0];
  end
  sim_cfg_loader u_a (
    .clk(clk), .rst(rst[0]), .ram_addr(addr[0]), .ram_read(rd[0]), .ram_rdata(rdata[0]),
    .orbit_start(orb[0]), .freeze(frz[0]), .cfg_active(act_a), .cfg_update(upd[0]),
    .cfg_changed(chg[0]), .missed_commits(miss[0])
  );
  sim_cfg_loader #(.N_WORDS(6), .BASE_ADDR(120), .RD_LATENCY(3), .RESET_CFG(RB)) u_b (
    .clk(clk), .rst(rst[1]), .ram_addr(addr[1]), .ram_read(rd[1]), .ram_rdata(rdata[1]),
    .orbit_start(orb[1]), .freeze(frz[1]), .cfg_active(act_b), .cfg_update(upd[1]),
    .cfg_changed(chg[1]), .missed_commits(miss[1])
  );
  int n_pass = 0, n_tot = 0;
  int nw [2] = '{4, 6};
  int lat [2] = '{1, 3};
  int base [2] = '{0, 120};
  logic [47:0] rcfg [2] = '{48'h0, RB};
  int ea [2] = '{0, 0};
  int sa [2] = '{0, 0};
  logic [47:0] m_act [2];
  logic [47:0] m_sh [2];
  logic [7:0] m_miss [2];
  logic m_upd [2];
  logic m_chg [2];
  logic m_rd [2];
  logic [6:0] m_addr [2];
  function automatic logic [47:0] snap(input int d);
    logic [47:0] r = '0;
    for (int i = 0; i < nw[d]; i++) r[i*8 +: 8] = mem[d][base[d]+i];
    return r;
  endfunction
  task automatic mreset(input int d);
    m_act[d] = rcfg[d]; m_sh[d] = rcfg[d]; m_miss[d] = 0;
    m_upd[d] = 0; m_chg[d] = 0; m_rd[d] = 0; m_addr[d] = 7'(base[d]);
  endtask
  // One clock with orbit/freeze driven; the model works from the time since the scan began:
  // reads at offsets 1..N, shadow complete at N+L, commits accepted only after that.
  task automatic step(input int d, input bit o, input bit f);
    int k;
    orb[d] = o; frz[d] = f;
    @(posedge clk); #1;
    orb[d] = 0;
    ea[d]++;
    if (rst[d]) begin
      sa[d] = ea[d];
      return;
    end
    k = ea[d] - sa[d];
    m_upd[d] = 0; m_chg[d] = 0;
    m_rd[d] = k >= 1 && k <= nw[d];
    if (m_rd[d]) m_addr[d] = 7'(base[d] + k - 1);
    if (k == nw[d] + lat[d]) m_sh[d] = snap(d);
    if (o && k > nw[d] + lat[d]) begin
      if (!f) begin
        m_upd[d] = 1; m_chg[d] = m_sh[d] != m_act[d]; m_act[d] = m_sh[d]; sa[d] = ea[d];
      end
    end else if (o && m_miss[d] != 8'hFF) m_miss[d]++;
  endtask
  task automatic test_reset();
    repeat (2) @(posedge clk);
    #1;
    for (int d = 0; d < 2; d++) begin
      n_tot++;
      if ({rd[d], addr[d]} !== {m_rd[d], m_addr[d]}) $display("FAIL reset_rdport d%0d got %h exp %h", d, {rd[d], addr[d]}, {m_rd[d], m_addr[d]});
      else n_pass++;
      n_tot++;
      if ({act[d], upd[d], chg[d], miss[d]} !== {m_act[d], m_upd[d], m_chg[d], m_miss[d]}) $display("FAIL reset_status d%0d got %h exp %h", d, {act[d], upd[d], chg[d], miss[d]}, {m_act[d], m_upd[d], m_chg[d], m_miss[d]});
      else n_pass++;
    end
  endtask
  task automatic test_scan_first_commit();
    rst[0] = 0; sa[0] = ea[0];
    for (int j = 1; j <= 5; j++) begin
      step(0, 0, 0);
      n_tot++;
      if ({rd[0], addr[0], act_a} !== {m_rd[0], m_addr[0], m_act[0][31:0]}) $display("FAIL scan_a j%0d got %h exp %h", j, {rd[0], addr[0], act_a}, {m_rd[0], m_addr[0], m_act[0][31:0]});
      else n_pass++;
    end
    step(0, 1, 0);
    n_tot++;
    if ({act_a, upd[0], chg[0]} !== {32'h011F1040, 2'b11}) $display("FAIL first_commit got %h exp %h", {act_a, upd[0], chg[0]}, {32'h011F1040, 2'b11});
    else n_pass++;
    step(0, 0, 0);
    n_tot++;
    if (upd[0] !== 1'b0) $display("FAIL update_one_cycle got %b exp 0", upd[0]);
    else n_pass++;
  endtask
  task automatic test_unchanged();
    repeat (5) step(0, 0, 0);
    step(0, 1, 0);
    n_tot++;
    if ({act_a, upd[0], chg[0]} !== {32'h011F1040, 2'b10}) $display("FAIL unchanged got %h exp %h", {act_a, upd[0], chg[0]}, {32'h011F1040, 2'b10});
    else n_pass++;
  endtask
  task automatic test_miss();
    for (int j = 1; j <= 6; j++) begin
      step(0, j == 2 || j >= 5, 0);
      n_tot++;
      if ({act[0], upd[0], chg[0], miss[0]} !== {m_act[0], m_upd[0], m_chg[0], m_miss[0]}) $display("FAIL miss j%0d got %h exp %h", j, {act[0], upd[0], chg[0], miss[0]}, {m_act[0], m_upd[0], m_chg[0], m_miss[0]});
      else n_pass++;
    end
    n_tot++;
    if ({miss[0], upd[0]} !== {8'd2, 1'b1}) $display("FAIL miss_count got %h exp %h", {miss[0], upd[0]}, {8'd2, 1'b1});
    else n_pass++;
  endtask
  task automatic test_freeze();
    repeat (6) step(0, 0, 0);
    mem[0][0] = 8'h7F;
    for (int j = 0; j < 4; j++) begin
      step(0, j[0] == 1'b0, 1);
      n_tot++;
      if ({act[0], upd[0], chg[0], miss[0]} !== {m_act[0], m_upd[0], m_chg[0], m_miss[0]}) $display("FAIL freeze j%0d got %h exp %h", j, {act[0], upd[0], chg[0], miss[0]}, {m_act[0], m_upd[0], m_chg[0], m_miss[0]});
      else n_pass++;
    end
    step(0, 1, 0);
    n_tot++;
    if ({act_a[7:0], upd[0]} !== {8'h40, 1'b1}) $display("FAIL unfreeze_old got %h exp %h", {act_a[7:0], upd[0]}, {8'h40, 1'b1});
    else n_pass++;
    repeat (5) step(0, 0, 0);
    step(0, 1, 0);
    n_tot++;
    if ({act_a, upd[0], chg[0]} !== {32'h011F107F, 2'b11}) $display("FAIL unfreeze_new got %h exp %h", {act_a, upd[0], chg[0]}, {32'h011F107F, 2'b11});
    else n_pass++;
  endtask
  task automatic test_reset_mid_scan();
    repeat (3) step(0, 0, 0);
    n_tot++;
    if ({rd[0], addr[0]} !== {1'b1, 7'd2}) $display("FAIL pre_reset_addr got %h exp %h", {rd[0], addr[0]}, {1'b1, 7'd2});
    else n_pass++;
    #2 rst[0] = 1;
    #1;
    mreset(0);
    n_tot++;
    if ({rd[0], addr[0], act[0], upd[0], chg[0], miss[0]} !== {m_rd[0], m_addr[0], m_act[0], m_upd[0], m_chg[0], m_miss[0]}) $display("FAIL async_reset got %h exp %h", {rd[0], addr[0], act[0], upd[0], chg[0], miss[0]}, {m_rd[0], m_addr[0], m_act[0], m_upd[0], m_chg[0], m_miss[0]});
    else n_pass++;
    for (int i = 0; i < 4; i++) mem[0][i] = 8'($urandom);
    repeat (2) step(0, 0, 0);
    rst[0] = 0;
    for (int j = 1; j <= 6; j++) begin
      step(0, j == 6, 0);
      n_tot++;
      if ({rd[0], addr[0], act[0], upd[0], chg[0]} !== {m_rd[0], m_addr[0], m_act[0], m_upd[0], m_chg[0]}) $display("FAIL rescan j%0d got %h exp %h", j, {rd[0], addr[0], act[0], upd[0], chg[0]}, {m_rd[0], m_addr[0], m_act[0], m_upd[0], m_chg[0]});
      else n_pass++;
    end
  endtask
  task automatic test_random_a();
    for (int j = 0; j < 250; j++) begin
      step(0, $urandom_range(0, 3) == 0, $urandom_range(0, 5) == 0);
      n_tot++;
      if ({rd[0], addr[0], act[0], upd[0], chg[0], miss[0]} !== {m_rd[0], m_addr[0], m_act[0], m_upd[0], m_chg[0], m_miss[0]}) $display("FAIL random_a j%0d got %h exp %h", j, {rd[0], addr[0], act[0], upd[0], chg[0], miss[0]}, {m_rd[0], m_addr[0], m_act[0], m_upd[0], m_chg[0], m_miss[0]});
      else n_pass++;
      if (ea[0] - sa[0] > nw[0] + lat[0] && $urandom_range(0, 2) == 0) mem[0][$urandom_range(0, 3)] = 8'($urandom);
    end
  endtask
  task automatic test_wide_config();
    rst[1] = 0; sa[1] = ea[1];
    for (int j = 1; j <= 10; j++) begin
      step(1, j >= 9, 0);
      n_tot++;
      if ({rd[1], addr[1], act[1], upd[1], chg[1], miss[1]} !== {m_rd[1], m_addr[1], m_act[1], m_upd[1], m_chg[1], m_miss[1]}) $display("FAIL wide_scan j%0d got %h exp %h", j, {rd[1], addr[1], act[1], upd[1], chg[1], miss[1]}, {m_rd[1], m_addr[1], m_act[1], m_upd[1], m_chg[1], m_miss[1]});
      else n_pass++;
    end
    for (int i = 0; i < 6; i++) begin
      n_tot++;
      if (act_b[i*8 +: 8] !== mem[1][120+i]) $display("FAIL wide_slice%0d got %h exp %h", i, act_b[i*8 +: 8], mem[1][120+i]);
      else n_pass++;
    end
    for (int j = 0; j < 340; j++) begin
      step(1, 1, 0);
      n_tot++;
      if ({act[1], upd[1], chg[1], miss[1]} !== {m_act[1], m_upd[1], m_chg[1], m_miss[1]}) $display("FAIL wide_flood j%0d got %h exp %h", j, {act[1], upd[1], chg[1], miss[1]}, {m_act[1], m_upd[1], m_chg[1], m_miss[1]});
      else n_pass++;
      if (j % 10 == 0 && ea[1] - sa[1] == 0) mem[1][120 + $urandom_range(0, 5)] = 8'($urandom);
    end
    n_tot++;
    if (miss[1] !== 8'hFF) $display("FAIL miss_saturate got %h exp ff", miss[1]);
    else n_pass++;
  endtask
  initial begin
    for (int d = 0; d < 2; d++) begin
      for (int i = 0; i < 128; i++) mem[d][i] = 8'($urandom);
      rst[d] = 1; orb[d] = 0; frz[d] = 0;
      mreset(d);
    end
    mem[0][0] = 8'h40; mem[0][1] = 8'h10; mem[0][2] = 8'h1F; mem[0][3] = 8'h01;
    test_reset();
    test_scan_first_commit();
    test_unchanged();
    test_miss();
    test_freeze();
    test_reset_mid_scan();
    test_random_a();
    test_wide_config();
    $display("%0d/%0d checks passed", n_pass, n_tot);
    $finish;
  end
endmodule
